// File: rtl/pe_pkg.sv
// Shared types and helpers for the PE stream driver.
// Capture-window bounds are derived from the kernel size, row length and PE latency.
package pe_pkg;

   localparam int unsigned DATA_W = 8;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      KERNEL,
      STREAM,
      DONE
   } drv_state_t;

   // First stream cycle whose output_sum holds a complete window.
   function automatic int unsigned cap_first(input int unsigned taps, input int unsigned lat);
      return taps - 1 + lat;
   endfunction

   // Stream cycle carrying the window that ends on the last ifmap sample.
   function automatic int unsigned cap_last(input int unsigned len, input int unsigned lat);
      return len - 1 + lat;
   endfunction

endpackage

// File: rtl/pe_row_buffer.sv
// One ifmap row of storage: indexed write port, combinational indexed read, async clear.
// Reads at an index past the end return zero, which the driver uses as stream padding.
module pe_row_buffer import pe_pkg::*; #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = DATA_W,
   parameter int unsigned IW    = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [IW-1:0]    wr_idx,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [IW-1:0]    rd_idx,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         for (int unsigned i = 0; i < DEPTH; i++)
            if (wr_en && wr_idx == IW'(i)) mem[i] <= wr_data;
      end
   end

   always_comb begin
      rd_data = '0;
      for (int unsigned i = 0; i < DEPTH; i++)
         if (rd_idx == IW'(i)) rd_data = mem[i];
   end

endmodule

// File: rtl/pe_stream_driver.sv
// PE initiator: buffers a kernel and one ifmap row, loads the kernel, streams the row
// gap-free and captures output_sum on the cycles where valid convolution windows emerge.
module pe_stream_driver #(
   parameter int unsigned TOTAL_WEIGHTS = 3,
   parameter int unsigned IFMAP_LEN     = 8,
   parameter int unsigned PE_LATENCY    = 2,
   parameter int unsigned DATA_W        = pe_pkg::DATA_W,
   localparam int unsigned AW = (TOTAL_WEIGHTS > 1) ? $clog2(TOTAL_WEIGHTS) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] bias_in,
   input  logic              wgt_wr_en,
   input  logic [AW-1:0]     wgt_wr_addr,
   input  logic [DATA_W-1:0] wgt_wr_data,
   input  logic              row_valid,
   output logic              row_ready,
   input  logic [DATA_W-1:0] row_data,
   output logic [DATA_W-1:0] weights_out [TOTAL_WEIGHTS],
   output logic              write_kernel,
   output logic [DATA_W-1:0] ifmap_out,
   output logic [DATA_W-1:0] partial_sum_out,
   input  logic [DATA_W-1:0] output_sum_in,
   output logic              res_valid,
   output logic [DATA_W-1:0] res_data,
   output logic              busy,
   output logic              done
);

   import pe_pkg::*;

   localparam int unsigned   CW      = $clog2(IFMAP_LEN + PE_LATENCY + 1);
   localparam logic [CW-1:0] CAP_LO  = CW'(cap_first(TOTAL_WEIGHTS, PE_LATENCY));
   localparam logic [CW-1:0] CAP_HI  = CW'(cap_last(IFMAP_LEN, PE_LATENCY));
   localparam logic [CW-1:0] LAST_WR = CW'(IFMAP_LEN - 1);

   drv_state_t        state, state_nx;
   logic [CW-1:0]     wr_idx, t, rd_idx;
   logic [DATA_W-1:0] kernel [TOTAL_WEIGHTS];
   logic [DATA_W-1:0] bias, rd_data;
   logic              load_hs, capture;

   assign row_ready = (state == LOAD);
   assign busy      = (state != IDLE);
   assign done      = (state == DONE);
   assign load_hs   = (state == LOAD) && row_valid;
   assign capture   = (state == STREAM) && (t >= CAP_LO) && (t <= CAP_HI);
   // Read one sample ahead so ifmap_out is registered yet shows buf[t] during cycle t.
   assign rd_idx    = (state == STREAM) ? t + 1'b1 : '0;

   pe_row_buffer #(
      .DEPTH (IFMAP_LEN),
      .WIDTH (DATA_W),
      .IW    (CW)
   ) u_buf (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (load_hs),
      .wr_idx  (wr_idx),
      .wr_data (row_data),
      .rd_idx  (rd_idx),
      .rd_data (rd_data)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (start) state_nx = LOAD;
         LOAD:    if (load_hs && wr_idx == LAST_WR) state_nx = KERNEL;
         KERNEL:  state_nx = STREAM;
         STREAM:  if (t == CAP_HI) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_idx          <= '0;
         t               <= '0;
         bias            <= '0;
         write_kernel    <= 1'b0;
         ifmap_out       <= '0;
         partial_sum_out <= '0;
         res_valid       <= 1'b0;
         res_data        <= '0;
         for (int unsigned i = 0; i < TOTAL_WEIGHTS; i++) begin
            kernel[i]      <= '0;
            weights_out[i] <= '0;
         end
      end else begin
         if (state == IDLE) begin
            for (int unsigned i = 0; i < TOTAL_WEIGHTS; i++)
               if (wgt_wr_en && wgt_wr_addr == AW'(i)) kernel[i] <= wgt_wr_data;
            if (start) begin
               bias   <= bias_in;
               wr_idx <= '0;
            end
         end
         if (load_hs) wr_idx <= wr_idx + 1'b1;

         write_kernel <= (state == LOAD) && (state_nx == KERNEL);
         if ((state == LOAD) && (state_nx == KERNEL))
            for (int unsigned i = 0; i < TOTAL_WEIGHTS; i++) weights_out[i] <= kernel[i];

         t               <= (state == STREAM) ? t + 1'b1 : '0;
         ifmap_out       <= (state_nx == STREAM) ? rd_data : '0;
         partial_sum_out <= (state_nx == STREAM) ? bias : '0;

         res_valid <= capture;
         if (capture) res_data <= output_sum_in;
      end
   end

endmodule

// File: tb/tb_pe_stream_driver.sv
// Directed bench for pe_stream_driver: two instances (row lengths 5 and 3), each driving
// a behavioural PE that registers the window sum two cycles after the newest sample.
module tb_pe_stream_driver;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, start5, start3, wgt_wr_en, row_valid;
   logic [1:0] wgt_wr_addr;
   logic [7:0] bias_in, wgt_wr_data, row_data;

   logic       rdy5, wk5, rv5, bsy5, dn5;
   logic [7:0] wo5 [3];
   logic [7:0] if5, ps5, os5, rd5;
   logic       rdy3, wk3, rv3, bsy3, dn3;
   logic [7:0] wo3 [3];
   logic [7:0] if3, ps3, os3, rd3;

   pe_stream_driver #(.TOTAL_WEIGHTS(3), .IFMAP_LEN(5), .PE_LATENCY(2), .DATA_W(8)) dut5 (
      .clk(clk), .rst(rst), .start(start5), .bias_in(bias_in),
      .wgt_wr_en(wgt_wr_en), .wgt_wr_addr(wgt_wr_addr), .wgt_wr_data(wgt_wr_data),
      .row_valid(row_valid), .row_ready(rdy5), .row_data(row_data),
      .weights_out(wo5), .write_kernel(wk5), .ifmap_out(if5), .partial_sum_out(ps5),
      .output_sum_in(os5), .res_valid(rv5), .res_data(rd5), .busy(bsy5), .done(dn5));

   pe_stream_driver #(.TOTAL_WEIGHTS(3), .IFMAP_LEN(3), .PE_LATENCY(2), .DATA_W(8)) dut3 (
      .clk(clk), .rst(rst), .start(start3), .bias_in(bias_in),
      .wgt_wr_en(wgt_wr_en), .wgt_wr_addr(wgt_wr_addr), .wgt_wr_data(wgt_wr_data),
      .row_valid(row_valid), .row_ready(rdy3), .row_data(row_data),
      .weights_out(wo3), .write_kernel(wk3), .ifmap_out(if3), .partial_sum_out(ps3),
      .output_sum_in(os3), .res_valid(rv3), .res_data(rd3), .busy(bsy3), .done(dn3));

   // Behavioural PEs: xs holds the last three samples (oldest first); os lags by two edges.
   logic [7:0] pw5 [3], xs5 [3], pq5;
   logic [7:0] pw3 [3], xs3 [3], pq3;
   always @(posedge clk) begin
      if (wk5) pw5 <= wo5;
      xs5[0] <= xs5[1]; xs5[1] <= xs5[2]; xs5[2] <= if5;
      pq5 <= ps5;
      os5 <= pw5[0] * xs5[0] + pw5[1] * xs5[1] + pw5[2] * xs5[2] + pq5;
      if (wk3) pw3 <= wo3;
      xs3[0] <= xs3[1]; xs3[1] <= xs3[2]; xs3[2] <= if3;
      pq3 <= ps3;
      os3 <= pw3[0] * xs3[0] + pw3[1] * xs3[1] + pw3[2] * xs3[2] + pq3;
   end

   bit         use3;
   logic       rdy, wk, rv, bsy, dn;
   logic [7:0] ifm, psm, rdat, wo0;
   assign rdy  = use3 ? rdy3 : rdy5;
   assign wk   = use3 ? wk3  : wk5;
   assign rv   = use3 ? rv3  : rv5;
   assign bsy  = use3 ? bsy3 : bsy5;
   assign dn   = use3 ? dn3  : dn5;
   assign ifm  = use3 ? if3  : if5;
   assign psm  = use3 ? ps3  : ps5;
   assign rdat = use3 ? rd3  : rd5;
   assign wo0  = use3 ? wo3[0] : wo5[0];

   int errs   = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic wr_w(input logic [1:0] a, input logic [7:0] d);
      wgt_wr_en = 1'b1; wgt_wr_addr = a; wgt_wr_data = d;
      @(negedge clk);
      wgt_wr_en = 1'b0;
   endtask

   task automatic run_job(input string tag, input logic [7:0] row [$], input bit gaps,
                          input int wr_tap, input logic [7:0] wr_val, input bit poke,
                          input int rst_at, input logic [7:0] exp [$]);
      int k, c, wk_n, wk_c, dn_n, first_rv, last_rv;
      bit hs;
      logic [7:0] got [$];
      if (use3) start3 = 1'b1; else start5 = 1'b1;
      if (wr_tap >= 0) begin
         wgt_wr_en = 1'b1; wgt_wr_addr = 2'(wr_tap); wgt_wr_data = wr_val;
      end
      @(negedge clk);
      start3 = 1'b0; start5 = 1'b0; wgt_wr_en = 1'b0;
      chk({tag, " busy_load"}, bsy, 1);
      k = 0; c = 0;
      while (k < row.size() && c < 60) begin
         row_valid = gaps ? (c % 3 == 0) : 1'b1;
         row_data  = row[k];
         hs = row_valid && rdy;
         @(negedge clk);
         if (hs) k++;
         c++;
      end
      row_valid = 1'b0;
      chk({tag, " loaded"}, k, row.size());
      wk_n = 0; wk_c = -1; dn_n = 0; first_rv = -1; last_rv = -1;
      for (c = 0; c < 40 && dn_n == 0; c++) begin
         if (poke && c == 3) begin
            if (use3) start3 = 1'b1; else start5 = 1'b1;
            wgt_wr_en = 1'b1; wgt_wr_addr = 2'd0; wgt_wr_data = 8'd9;
         end
         if (poke && c == 4) begin
            start3 = 1'b0; start5 = 1'b0; wgt_wr_en = 1'b0;
         end
         if (wk) begin wk_n++; wk_c = c; end
         if (wk_c >= 0 && c > wk_c && c <= wk_c + row.size())
            chk({tag, " ifmap"}, ifm, row[c - wk_c - 1]);
         if (wk_c >= 0 && c == wk_c + row.size() + 1)
            chk({tag, " ifmap_pad"}, ifm, 0);
         if (rv) begin
            got.push_back(rdat);
            if (first_rv < 0) first_rv = c;
            last_rv = c;
         end
         if (dn) dn_n++;
         if (c == rst_at) begin
            rst = 1'b1;
            #1;
            chk({tag, " rst_busy"}, bsy, 0);
            chk({tag, " rst_ifmap"}, ifm, 0);
            chk({tag, " rst_psum"}, psm, 0);
            chk({tag, " rst_wgt0"}, wo0, 0);
            chk({tag, " rst_res"}, {rv, rdat}, 0);
            chk({tag, " rst_rdy_wk"}, {rdy, wk}, 0);
            @(negedge clk);
            chk({tag, " rst_done"}, dn, 0);
            rst = 1'b0;
            repeat (8) begin
               @(negedge clk);
               if (dn || bsy) chk({tag, " post_rst_idle"}, {dn, bsy}, 0);
            end
            chk({tag, " post_rst_busy"}, bsy, 0);
            return;
         end
         @(negedge clk);
      end
      chk({tag, " write_kernel_cycles"}, wk_n, 1);
      chk({tag, " done_pulses"}, dn_n, 1);
      chk({tag, " done_low"}, dn, 0);
      chk({tag, " busy_end"}, bsy, 0);
      chk({tag, " res_count"}, got.size(), exp.size());
      chk({tag, " res_contig"}, last_rv - first_rv + 1, exp.size());
      for (int i = 0; i < exp.size() && i < got.size(); i++)
         chk($sformatf("%s res%0d", tag, i), got[i], exp[i]);
   endtask

   logic [7:0] row5 [$], row3 [$], exp_a [$], exp_b [$], exp_c [$], none [$];

   initial begin
      rst = 1'b1; start5 = 1'b0; start3 = 1'b0; use3 = 1'b0;
      wgt_wr_en = 1'b0; wgt_wr_addr = '0; wgt_wr_data = '0;
      row_valid = 1'b0; row_data = '0; bias_in = '0;
      row5  = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
      row3  = '{8'd255, 8'd255, 8'd255};
      exp_a = '{8'd14, 8'd20, 8'd26};
      exp_b = '{8'd20, 8'd28, 8'd36};
      exp_c = '{8'd253};
      repeat (2) @(negedge clk);
      chk("reset busy", {bsy5, bsy3}, 0);
      chk("reset ready", {rdy5, rdy3}, 0);
      chk("reset write_kernel", {wk5, wk3}, 0);
      chk("reset res", {rv5, rd5}, 0);
      chk("reset done", {dn5, dn3}, 0);
      chk("reset pe_outs", {if5, ps5, wo5[0], wo5[2]}, 0);
      rst = 1'b0;
      @(negedge clk);

      wr_w(2'd0, 8'd1); wr_w(2'd1, 8'd2); wr_w(2'd2, 8'd3);
      run_job("basic",      row5, 1'b0, -1, 8'd0, 1'b0, -1, exp_a);
      run_job("gaps",       row5, 1'b1, -1, 8'd0, 1'b0, -1, exp_a);
      run_job("poke",       row5, 1'b0, -1, 8'd0, 1'b1, -1, exp_a);
      run_job("after_poke", row5, 1'b0, -1, 8'd0, 1'b0, -1, exp_a);
      run_job("wr_start",   row5, 1'b0,  2, 8'd5, 1'b0, -1, exp_b);
      run_job("reset",      row5, 1'b0, -1, 8'd0, 1'b0,  3, none);
      wr_w(2'd0, 8'd1); wr_w(2'd1, 8'd2); wr_w(2'd2, 8'd3);
      run_job("post_reset", row5, 1'b0, -1, 8'd0, 1'b0, -1, exp_a);

      use3 = 1'b1;
      wr_w(2'd0, 8'd1); wr_w(2'd1, 8'd1); wr_w(2'd2, 8'd1);
      run_job("wrap",       row3, 1'b0, -1, 8'd0, 1'b0, -1, exp_c);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/pe_stream_driver.md
Name: pe_stream_driver

Overview:
Initiator side of the PE interface. Buffers one kernel and one ifmap row from upstream, loads the kernel into a PE with a single write_kernel pulse, then streams the row gap-free. It captures the PE's output_sum at the cycles where valid convolution windows emerge and presents them on a result stream. Sits between the on-chip buffer/controller and each PE row.

Parameters:
TOTAL_WEIGHTS, 3, kernel taps; must match the attached PE.
IFMAP_LEN, 8, ifmap samples per row; must be >= TOTAL_WEIGHTS.
PE_LATENCY, 2, cycles from the PE sampling ifmap sample j to output_sum reflecting the window that ends at j.
DATA_W, 8, width of every data path.

Ports:
clk  in  1  clock; all logic on the rising edge.
rst  in  1  asynchronous, active-high reset.
start  in  1  launch a row job; honoured only in IDLE.
bias_in  in  DATA_W  partial-sum seed; latched when start is accepted.
wgt_wr_en  in  1  kernel register write strobe; honoured only in IDLE.
wgt_wr_addr  in  clog2(TOTAL_WEIGHTS)  tap index; an out-of-range value is ignored.
wgt_wr_data  in  DATA_W  tap value.
row_valid  in  1  upstream ifmap sample valid.
row_ready  out  1  driver accepts a sample.
row_data  in  DATA_W  ifmap sample.
weights_out  out  DATA_W x TOTAL_WEIGHTS  unpacked array to PE weights_in.
write_kernel  out  1  one-cycle kernel load pulse to PE.
ifmap_out  out  DATA_W  to PE ifmap_in.
partial_sum_out  out  DATA_W  to PE partial_sum_in.
output_sum_in  in  DATA_W  from PE output_sum.
res_valid  out  1  res_data holds a valid window result; no backpressure.
res_data  out  DATA_W  captured window result.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse at job end.

Behaviour:
- Reset: state IDLE. row_ready, write_kernel, res_valid, busy and done are 0. ifmap_out, partial_sum_out, res_data and all weights_out entries are 0. Kernel registers, row buffer and counters are cleared. Reset mid-job aborts the job with no done pulse.
- All PE-facing outputs and res_* are registered.
- States: IDLE -> LOAD -> KERNEL -> STREAM -> DONE -> IDLE.
- IDLE:
  - A wgt_wr_en write updates its tap on the next edge.
  - If a write and start arrive in the same cycle, the write lands and the new value is used for that job.
  - start latches bias_in and moves to LOAD.
- LOAD:
  - row_ready = 1.
  - Each row_valid & row_ready cycle stores row_data at wr_idx and increments wr_idx.
  - After the IFMAP_LEN-th handshake, row_ready drops on the next cycle and the state moves to KERNEL.
  - Upstream gaps are allowed and simply stall LOAD.
- KERNEL:
  - Exactly one cycle with write_kernel = 1 and weights_out driven from the kernel registers.
  - weights_out keeps its value after this cycle.
- STREAM:
  - Cycle counter t starts at 0 and increments every cycle.
  - For t < IFMAP_LEN: ifmap_out = buf[t], partial_sum_out = bias. For t >= IFMAP_LEN: ifmap_out = 0.
  - The row is never paused during STREAM.
- Capture:
  - Capture is active when TOTAL_WEIGHTS-1+PE_LATENCY <= t <= IFMAP_LEN-1+PE_LATENCY.
  - On those cycles, on the next edge, res_data <= output_sum_in and res_valid = 1.
  - This yields exactly IFMAP_LEN-TOTAL_WEIGHTS+1 results, contiguous.
  - The state moves to DONE after the last capture cycle.
- DONE:
  - done = 1 for one cycle; ifmap_out and partial_sum_out return to 0.
  - The state returns to IDLE.
- Ignored inputs: start and wgt_wr_en are ignored while busy. row_valid is ignored outside LOAD.
- Arithmetic: the driver performs none; values pass through unchanged, with DATA_W wrap owned by the PE.
- Counters: wr_idx and t are sized for IFMAP_LEN+PE_LATENCY with no wrap-around.

Decomposition:
- Package pe_pkg:
  - DATA_W localparam.
  - Enum drv_state_t {IDLE, LOAD, KERNEL, STREAM, DONE}.
  - Helper function for capture-window bounds.
- Sub-module pe_row_buffer holds the row storage:
  - IFMAP_LEN x DATA_W registers.
  - Write port with index; combinational read by index.
  - Async clear.

Test Plan:
- Basic job:
  - Stimulus: weights {1,2,3}, row {1,2,3,4,5}, IFMAP_LEN=5, bias 0, bench PE model computing sum w[i]*x[k+i] with PE_LATENCY=2.
  - Required: write_kernel high exactly 1 cycle, then ifmap_out 1..5 on consecutive cycles, res_valid 3 consecutive cycles with 14, 20, 26, then one done pulse.
- Upstream gaps: row_valid toggles 1,0,0,1,... during LOAD. Required: stored row identical to the gap-free case, STREAM output unchanged, same results 14, 20, 26.
- Ignored requests:
  - Stimulus: start and wgt_wr_en (tap 0 = 9) asserted during STREAM.
  - Required: no restart, kernel unchanged for this job and the next.
- Write and start together: wgt_wr_en (tap 2 = 5) together with start in IDLE. Required: the job uses weights {1,2,5}, first result 1+4+15 = 20.
- Reset mid-job: rst asserted mid-STREAM. Required: all outputs 0 immediately without waiting for a clock edge, no done pulse, busy = 0. A fresh job afterwards produces the correct results.
- Wrap-around: row {255,255,255}, weights {1,1,1}, IFMAP_LEN=3. Required: single res_valid with res_data = 253 (8-bit wrap passed through).
